udma_uart_tx_arb: RTL and testbench
===================================

// Module: udma_uart_tx_arb
// PURPOSE
// - Round-robin arbiter sharing the single UART TX byte stream between NUM_REQ byte sources.
// - Typical sources: the uDMA TX channel and a register-level direct-write path.
// - Sits in the sys_clk_i domain, ahead of the TX dual-clock FIFO; its output feeds that FIFO's source side.
// - Bounded bursts keep each byte from any source contiguous while preventing starvation.
// PARAMETERS
// - NUM_REQ     2  number of requesters (>=2)
// - DATA_WIDTH  8  byte width of each stream
// - BURST_W     4  width of cfg_burst_i
// PORTS
// - sys_clk_i    in   1                   system clock
// - rstn_i       in   1                   reset, asynchronous, active-low
// - cfg_en_i     in   1                   arbiter enable; 0 = no new grants
// - cfg_mask_i   in   NUM_REQ             per-requester enable; 1 = eligible
// - cfg_burst_i  in   BURST_W             max bytes per grant, minus 1
// - req_data_i   in   NUM_REQ*DATA_WIDTH  requester bytes; requester i uses [i*DATA_WIDTH +: DATA_WIDTH]
// - req_valid_i  in   NUM_REQ             requester byte valid
// - req_ready_o  out  NUM_REQ             requester byte accepted
// - out_data_o   out  DATA_WIDTH          registered output byte
// - out_valid_o  out  1                   output valid
// - out_ready_i  in   1                   downstream ready
// - out_src_o    out  $clog2(NUM_REQ)     index of requester that produced out_data_o
// - grant_o      out  NUM_REQ             one-hot current owner; 0 in IDLE
// - busy_o       out  1                   state==GRANT or out_valid_o
// BEHAVIOUR
// - Reset values: all outputs 0, state IDLE, rr_ptr=0, burst_cnt=0, owner=0.
// - Handshake: valid/ready. Transfer happens when valid & ready are both high at a clock edge.
// - Requester valid must stay high until ready; the block does not check this.
// - slot_free = ~out_valid_o | out_ready_i.
// - IDLE:
//   - Eligible set: req_valid_i & cfg_mask_i, qualified by cfg_en_i.
//   - If the eligible set is non-empty, select the first eligible index scanning upward from rr_ptr, wrapping modulo NUM_REQ.
//   - Latch owner, clear burst_cnt, go to GRANT.
//   - req_ready_o is 0 while in IDLE.
// - GRANT:
//   - req_ready_o[owner] = slot_free. All other req_ready_o bits are 0.
//   - On accept: out_data_o <= owner's byte, out_src_o <= owner, out_valid_o <= 1, burst_cnt++.
//   - Exit to IDLE at the clock edge where any of these holds:
//     (a) an accept occurs with burst_cnt==cfg_burst_i;
//     (b) req_valid_i[owner]==0;
//     (c) cfg_mask_i[owner]==0;
//     (d) cfg_en_i==0.
//   - In cases (b), (c) and (d) no byte is accepted in that cycle.
//   - On exit: rr_ptr <= (owner+1) mod NUM_REQ.
// - Output register:
//   - If out_ready_i is high and no new load occurs, out_valid_o <= 0.
//   - A load and a drain in the same cycle keep out_valid_o at 1 with the new byte.
//   - out_data_o and out_src_o are stable while out_valid_o & ~out_ready_i.
// - Latency:
//   - Valid in IDLE at cycle 0 -> grant_o at cycle 1 -> accept at cycle 1 if slot_free -> out_valid_o at cycle 2.
//   - Within a grant: 1 byte/cycle at full throughput.
//   - 1 idle bubble cycle between consecutive grants.
// - Arithmetic:
//   - burst_cnt is BURST_W bits; grant length is cfg_burst_i+1 bytes (1..2^BURST_W).
//   - burst_cnt never wraps because exit (a) fires at equality.
//   - rr_ptr wraps from NUM_REQ-1 to 0.
// - Boundaries:
//   - cfg_burst_i is sampled every cycle. Lowering it below burst_cnt mid-grant ends the grant at the next accept.
//   - cfg_en_i low does not flush out_valid_o: the held byte still drains.
//   - Reset mid-grant returns to the reset values immediately (asynchronous); the held output byte is dropped.
//   - Simultaneous valids from all requesters: strict rotation starting at rr_ptr.
//   - cfg_mask_i all-zero: remain in IDLE with busy_o = out_valid_o.
// TESTING
// 1. Reset, then valid[0] held with 3 bytes 0x11,0x22,0x33, cfg_burst=7, out_ready=1
//    -> out stream 11,22,33 on consecutive cycles; first out_valid 2 cycles after valid; out_src=0.
// 2. Both requesters continuously valid, cfg_burst=1, out_ready=1
//    -> sequence src 0,0,1,1,0,0; 1-cycle bubble between grants; rr_ptr alternates.
// 3. Backpressure: out_ready=0 for 5 cycles while granted
//    -> exactly one byte accepted; out_data stable; req_ready low until out_ready returns.
// 4. cfg_mask=2'b10 with both valid
//    -> only src 1 served; clear mask[1] mid-grant -> return to IDLE with no byte accepted that cycle.
// 5. cfg_en deasserted while out_valid=1, out_ready=0
//    -> byte held; released when out_ready=1; no further grants; busy_o drops after drain.
// 6. Assert rstn_i low mid-burst (byte 2 of 4)
//    -> all outputs 0 asynchronously; after release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/udma_uart_tx_arb.sv
// udma_uart_tx_arb
// Round-robin arbiter that merges NUM_REQ byte streams into the single UART TX
// byte stream feeding the TX dual-clock FIFO. Each grant is a bounded burst of
// cfg_burst_i+1 bytes, so one source's bytes stay contiguous without starving
// the other sources. The output byte is held in a one-entry register.
module udma_uart_tx_arb #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_W    = 4
) (
  input  logic                          sys_clk_i,
  input  logic                          rstn_i,
  input  logic                          cfg_en_i,
  input  logic [NUM_REQ-1:0]            cfg_mask_i,
  input  logic [BURST_W-1:0]            cfg_burst_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]    out_src_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t               state_reg;
  logic [IDX_W-1:0]     owner_reg;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [BURST_W-1:0]   burst_cnt_reg;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic [IDX_W-1:0]      scan_idx;
  logic [IDX_W-1:0]      pick;
  logic                  pick_found;
  logic                  in_grant;
  logic                  slot_free;
  logic                  owner_ok;
  logic                  owner_stay;
  logic                  accept;
  logic                  burst_done;
  logic                  grant_exit;

  assign slot_free = ~out_valid_o | out_ready_i;
  assign eligible  = req_valid_i & cfg_mask_i & {NUM_REQ{cfg_en_i}};
  assign in_grant  = (state_reg == S_GRANT);

  // The owner may keep transferring only while it stays enabled; ready is
  // gated by the same terms so a source never sees a handshake for a byte
  // that the arbiter refuses in that cycle.
  assign owner_ok   = in_grant & cfg_en_i & cfg_mask_i[owner_reg];
  assign owner_stay = owner_ok & req_valid_i[owner_reg];
  assign accept     = owner_stay & slot_free;
  // Compare with >= so lowering cfg_burst_i below the running count ends the
  // grant at the next accepted byte instead of running to counter wrap.
  assign burst_done = (burst_cnt_reg >= cfg_burst_i);
  assign grant_exit = in_grant & (~owner_stay | (accept & burst_done));
  assign busy_o     = in_grant | out_valid_o;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_data_arr[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready_o[gi]  = owner_ok & slot_free & (owner_reg == IDX_W'(gi));
  end

  // Round-robin pick: first eligible index scanning upward from rr_ptr, wrapping.
  always_comb begin
    scan_idx   = rr_ptr_reg;
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && eligible[scan_idx]) begin
        pick       = scan_idx;
        pick_found = 1'b1;
      end
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
    end
  end

  // Grant FSM: owner, burst count, rotation pointer and registered grant vector.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg     <= S_IDLE;
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
      grant_o       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pick_found) begin
            state_reg     <= S_GRANT;
            owner_reg     <= pick;
            burst_cnt_reg <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
              grant_o[i] <= (pick == IDX_W'(i));
            end
          end
        end
        S_GRANT: begin
          if (grant_exit) begin
            state_reg  <= S_IDLE;
            grant_o    <= '0;
            rr_ptr_reg <= (owner_reg == LAST_IDX) ? '0 : owner_reg + IDX_W'(1);
          end else if (accept) begin
            burst_cnt_reg <= burst_cnt_reg + BURST_W'(1);
          end
        end
        default: begin
          state_reg <= S_IDLE;
          grant_o   <= '0;
        end
      endcase
    end
  end

  // One-entry output register: load on accept, otherwise drain when downstream is ready.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_src_o   <= '0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_data_o  <= req_data_arr[owner_reg];
      out_src_o   <= owner_reg;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udma_uart_tx_arb.sv
// tb_udma_uart_tx_arb
// Directed bench for the UART TX round-robin arbiter (NUM_REQ=2, 8-bit bytes).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_udma_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [1:0]  mask;
  logic [3:0]  burst;
  logic [15:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_src;
  logic [1:0]  grant;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  fire;
  int          src_cnt [2];
  logic [7:0]  base [2];
  logic [7:0]  stride;

  always #5 clk = ~clk;

  udma_uart_tx_arb #(
    .NUM_REQ    (2),
    .DATA_WIDTH (8),
    .BURST_W    (4)
  ) dut (
    .sys_clk_i   (clk),
    .rstn_i      (rstn),
    .cfg_en_i    (en),
    .cfg_mask_i  (mask),
    .cfg_burst_i (burst),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_src_o   (out_src),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  // Each source presents base + n*stride as its n-th byte.
  task automatic drive_data();
    req_data[7:0]  = base[0] + 8'(src_cnt[0]) * stride;
    req_data[15:8] = base[1] + 8'(src_cnt[1]) * stride;
  endtask

  // Advance one clock; a source moves to its next byte after a handshake.
  task automatic step();
    @(negedge clk);
    fire = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (fire[i]) src_cnt[i]++;
    drive_data();
  endtask

  task automatic do_reset(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] s);
    rstn = 1'b0;
    req_valid = 2'b00; en = 1'b1; mask = 2'b11; burst = 4'd7; out_ready = 1'b1;
    src_cnt[0] = 0; src_cnt[1] = 0;
    base[0] = b0; base[1] = b1; stride = s;
    drive_data();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 2'b11; en = 1'b1; mask = 2'b11; burst = 4'd7; out_ready = 1'b1;
    req_data = 16'hBEEF;
    rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h exp 00", out_data); end
    checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL rst_out_src got %b exp 0", out_src); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", req_ready); end
    do_reset(8'h00, 8'h00, 8'h01);
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_idle_grant got %b exp 00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b exp 0", busy); end
  endtask

  // Single source, 3 bytes 11,22,33, burst limit 8.
  task automatic test_single();
    do_reset(8'h11, 8'h00, 8'h11);
    burst = 4'd7;
    req_valid = 2'b01;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL t1_idle_ready got %b exp 00", req_ready); end
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL t1_grant got %b exp 01", grant); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %b exp 0", out_valid); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t1_ready got %b exp 01", req_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 1'b0) begin errors++; $display("FAIL t1_byte0 got v=%b d=%h s=%b exp v=1 d=11 s=0", out_valid, out_data, out_src); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_src !== 1'b0) begin errors++; $display("FAIL t1_byte1 got v=%b d=%h s=%b exp v=1 d=22 s=0", out_valid, out_data, out_src); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_src !== 1'b0) begin errors++; $display("FAIL t1_byte2 got v=%b d=%h s=%b exp v=1 d=33 s=0", out_valid, out_data, out_src); end
    req_valid = 2'b00;
    step();
    checks++; if (out_valid !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL t1_end got v=%b g=%b b=%b exp v=0 g=00 b=0", out_valid, grant, busy); end
  endtask

  // Both sources always valid, 2-byte bursts: A0 A1 - B0 B1 - A2 A3.
  task automatic test_rotation();
    logic       exp_v [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_d [9] = '{8'h00, 8'hA0, 8'hA1, 8'h00, 8'hB0, 8'hB1, 8'h00, 8'hA2, 8'hA3};
    logic       exp_s [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] exp_g [9] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    do_reset(8'hA0, 8'hB0, 8'h01);
    burst = 4'd1;
    req_valid = 2'b11;
    step();
    for (int c = 0; c < 9; c++) begin
      checks++; if (out_valid !== exp_v[c]) begin errors++; $display("FAIL t2_valid c%0d got %b exp %b", c + 1, out_valid, exp_v[c]); end
      checks++; if (grant !== exp_g[c]) begin errors++; $display("FAIL t2_grant c%0d got %b exp %b", c + 1, grant, exp_g[c]); end
      if (exp_v[c]) begin
        checks++; if (out_data !== exp_d[c] || out_src !== exp_s[c]) begin errors++; $display("FAIL t2_byte c%0d got d=%h s=%b exp d=%h s=%b", c + 1, out_data, out_src, exp_d[c], exp_s[c]); end
      end
      step();
    end
    req_valid = 2'b00;
    step(); step();
  endtask

  // Downstream stalls 5 cycles while granted: one byte held, no more accepted.
  task automatic test_backpressure();
    do_reset(8'hC0, 8'h00, 8'h01);
    out_ready = 1'b0;
    req_valid = 2'b01;
    step();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t3_first_ready got %b exp 01", req_ready); end
    step();
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hC0) begin errors++; $display("FAIL t3_hold k%0d got v=%b d=%h exp v=1 d=c0", k, out_valid, out_data); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL t3_stall_ready k%0d got %b exp 00", k, req_ready); end
      step();
    end
    checks++; if (src_cnt[0] !== 1) begin errors++; $display("FAIL t3_accepted got %0d exp 1", src_cnt[0]); end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL t3_resume_ready got %b exp 01", req_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hC1) begin errors++; $display("FAIL t3_next got v=%b d=%h exp v=1 d=c1", out_valid, out_data); end
    req_valid = 2'b00;
    step(); step();
  endtask

  // Only requester 1 enabled; clearing its mask mid-grant ends the grant with no accept.
  task automatic test_mask();
    do_reset(8'hE0, 8'hF0, 8'h01);
    mask = 2'b10;
    req_valid = 2'b11;
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL t4_grant got %b exp 10", grant); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_src !== 1'b1) begin errors++; $display("FAIL t4_byte got v=%b d=%h s=%b exp v=1 d=f0 s=1", out_valid, out_data, out_src); end
    mask = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL t4_masked_ready got %b exp 00", req_ready); end
    step();
    checks++; if (grant !== 2'b00 || out_valid !== 1'b0) begin errors++; $display("FAIL t4_exit got g=%b v=%b exp g=00 v=0", grant, out_valid); end
    checks++; if (src_cnt[1] !== 1 || src_cnt[0] !== 0) begin errors++; $display("FAIL t4_counts got %0d/%0d exp 0/1", src_cnt[0], src_cnt[1]); end
    step(); step();
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL t4_idle got g=%b b=%b exp g=00 b=0", grant, busy); end
    req_valid = 2'b00;
  endtask

  // Disable while a byte is held: the byte drains, no new grants follow.
  task automatic test_disable();
    do_reset(8'h50, 8'h00, 8'h01);
    out_ready = 1'b0;
    req_valid = 2'b01;
    step(); step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h50) begin errors++; $display("FAIL t5_loaded got v=%b d=%h exp v=1 d=50", out_valid, out_data); end
    en = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL t5_ready got %b exp 00", req_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h50 || busy !== 1'b1 || grant !== 2'b00) begin errors++; $display("FAIL t5_held got v=%b d=%h b=%b g=%b exp v=1 d=50 b=1 g=00", out_valid, out_data, busy, grant); end
    step();
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t5_drain got v=%b b=%b exp v=0 b=0", out_valid, busy); end
    step();
    checks++; if (grant !== 2'b00 || src_cnt[0] !== 1) begin errors++; $display("FAIL t5_no_grant got g=%b n=%0d exp g=00 n=1", grant, src_cnt[0]); end
    req_valid = 2'b00;
    en = 1'b1;
  endtask

  // Reset during byte 2 of requester 1's 4-byte burst; rotation restarts at 0.
  task automatic test_reset_mid_burst();
    int n;
    do_reset(8'h30, 8'hD0, 8'h01);
    burst = 4'd3;
    req_valid = 2'b11;
    n = 0;
    while (grant !== 2'b10 && n < 20) begin
      step();
      n++;
    end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL t6_wait_grant got %b exp 10", grant); end
    step(); step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hD1 || out_src !== 1'b1) begin errors++; $display("FAIL t6_pre got v=%b d=%h s=%b exp v=1 d=d1 s=1", out_valid, out_data, out_src); end
    rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0) begin errors++; $display("FAIL t6_rst_out got v=%b d=%h s=%b exp 0 00 0", out_valid, out_data, out_src); end
    checks++; if (grant !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL t6_rst_ctl got g=%b b=%b r=%b exp 00 0 00", grant, busy, req_ready); end
    @(posedge clk); #1;
    rstn = 1'b1;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL t6_restart got %b exp 01", grant); end
    req_valid = 2'b00;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_mask();
    test_disable();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
